// File: rtl/arc_tan_pkg.sv
// arc_tan_pkg
// Shared types and constants for the Sobel edge-direction quantiser.
//   angle_t        : 2-bit signed Canny direction code
//   ANG_*          : direction codes for 0, 45, 90 and 135 degrees
//   *_DEF          : default gradient width and Q8 tangent thresholds
//   TAN_BITS       : bit budget of the Q8 tangent constants; products are
//                    widened by this many bits so ax*TAN never overflows
package arc_tan_pkg;

    typedef logic signed [1:0] angle_t;

    localparam angle_t ANG_0   = 2'sd0;
    localparam angle_t ANG_45  = 2'sd1;
    localparam angle_t ANG_90  = -2'sd2;
    localparam angle_t ANG_135 = -2'sd1;

    localparam int WIDTH_DEF    = 11;
    localparam int TAN22_Q8_DEF = 106;
    localparam int TAN67_Q8_DEF = 618;

    // Both tangent constants fit in 10 bits (618 < 1024).
    localparam int TAN_BITS = 10;

endpackage

// File: rtl/arc_tan_abs.sv
// arc_tan_abs
// Combinational two's-complement to magnitude conversion.
//   val     : WIDTH-bit signed input
//   abs_val : WIDTH-bit unsigned magnitude; the most negative input maps to
//             2^(WIDTH-1), which still fits because the output is unsigned
module arc_tan_abs
    import arc_tan_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic signed [WIDTH-1:0] val,
    output logic        [WIDTH-1:0] abs_val
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] raw;

    assign raw = val;

    // Negate through invert-plus-one on the raw bits; for -2^(WIDTH-1) this
    // wraps back to the same bit pattern, which read unsigned is the magnitude.
    assign abs_val = raw[WIDTH-1] ? (~raw + ONE) : raw;

endmodule

// File: rtl/arc_tan_quant.sv
// arc_tan_quant
// Quantises a Sobel gradient (Gx, Gy) into one of four Canny direction
// sectors using Q8 tangent thresholds and shift-add constant products.
// Two registered stages, valid strobe carried alongside the data.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : Gx/Gy valid this cycle
//   Gx, Gy    : WIDTH-bit signed gradients
//   out_valid : angle (and mag) valid, two edges after in_valid
//   angle     : 0=0deg, 1=45deg, -2=90deg, -1=135deg
//   mag       : |Gx|+|Gy|, only when ARC_TAN_MAG_EN is defined
// Optional feature macro: ARC_TAN_MAG_EN
module arc_tan_quant
    import arc_tan_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int TAN22_Q8 = TAN22_Q8_DEF,
    parameter int TAN67_Q8 = TAN67_Q8_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] Gx,
    input  logic signed [WIDTH-1:0] Gy,
    output logic                    out_valid,
    output logic signed [1:0]       angle
`ifdef ARC_TAN_MAG_EN
    ,
    output logic        [WIDTH:0]   mag
`endif
);

    localparam int PW = WIDTH + TAN_BITS;

    logic [WIDTH-1:0] gx_abs;
    logic [WIDTH-1:0] gy_abs;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_ax;
    logic [WIDTH-1:0] s1_ay;
    logic             s1_sgn_eq;
    logic             s1_nz;

    logic [PW-1:0]    ax_ext;
    logic [PW-1:0]    y_q8;
    logic [PW-1:0]    lo_q8;
    logic [PW-1:0]    hi_q8;
    angle_t           angle_nxt;

    arc_tan_abs #(.WIDTH(WIDTH)) u_abs_x (
        .val     (Gx),
        .abs_val (gx_abs)
    );

    arc_tan_abs #(.WIDTH(WIDTH)) u_abs_y (
        .val     (Gy),
        .abs_val (gy_abs)
    );

    // Stage 1: magnitudes plus the two sign/zero flags needed to tell the
    // diagonals apart. Data loads every cycle so idle slots stay deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_ax     <= '0;
            s1_ay     <= '0;
            s1_sgn_eq <= 1'b0;
            s1_nz     <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_ax     <= gx_abs;
            s1_ay     <= gy_abs;
            s1_sgn_eq <= (Gx[WIDTH-1] == Gy[WIDTH-1]);
            s1_nz     <= (Gx != '0) && (Gy != '0);
        end
    end

    assign ax_ext = {{TAN_BITS{1'b0}}, s1_ax};
    assign y_q8   = {{(TAN_BITS-8){1'b0}}, s1_ay, 8'b0};

    // Constant products ax*TAN as a sum of shifted copies of ax, one term per
    // set bit of the Q8 constant; comparing ay*256 against them is the same as
    // comparing ay/ax against the tangent without any divide.
    always_comb begin
        lo_q8 = '0;
        hi_q8 = '0;
        for (int i = 0; i < TAN_BITS; i++) begin
            if (TAN22_Q8[i]) lo_q8 = lo_q8 + (ax_ext << i);
            if (TAN67_Q8[i]) hi_q8 = hi_q8 + (ax_ext << i);
        end
    end

    // Sector decision. Equality with either threshold falls through to the
    // diagonal branch. A zero vector gives Y=L=H=0 and nz=0, landing on 0deg.
    always_comb begin
        angle_nxt = ANG_0;
        if (y_q8 < lo_q8) begin
            angle_nxt = ANG_0;
        end else if (y_q8 > hi_q8) begin
            angle_nxt = ANG_90;
        end else if (s1_nz) begin
            angle_nxt = s1_sgn_eq ? ANG_45 : ANG_135;
        end
    end

    // Stage 2: registered outputs aligned with the pipelined valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            angle     <= ANG_0;
        end else begin
            out_valid <= s1_valid;
            angle     <= angle_nxt;
        end
    end

`ifdef ARC_TAN_MAG_EN
    // L1 magnitude registered in the same stage as the angle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
        end else begin
            mag <= {1'b0, s1_ax} + {1'b0, s1_ay};
        end
    end
`else
    // Angle-only build: no magnitude register.
`endif

endmodule

// File: tb/tb_arc_tan_quant.sv
// tb_arc_tan_quant
// Scoreboard bench: applyStimulus pushes the expected response with the cycle
// it is due; a negedge monitor (checkOutput) compares out_valid every cycle
// and the data whenever a result is due. Define ARC_TAN_MAG_EN to also
// check mag.
module tb_arc_tan_quant;

    localparam real PI = 3.141592653589793;

    typedef struct {
        int                 due;
        logic signed [1:0]  ang;
        bit                 tol;
        logic        [11:0] mag;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic               out_valid;
    logic signed [1:0]  angle;
`ifdef ARC_TAN_MAG_EN
    logic        [11:0] mag;
`endif

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;

    arc_tan_quant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Gx        (gx),
        .Gy        (gy),
        .out_valid (out_valid),
        .angle     (angle)
`ifdef ARC_TAN_MAG_EN
        ,
        .mag       (mag)
`endif
    );

    // Free-running clock and cycle stamp used to time-tag expectations.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Real-valued reference: fold into the first quadrant with atan2, then
    // pick the diagonal from the sign relation.
    function automatic real ref_deg(input int x, input int y);
        return $atan2(real'(iabs(y)), real'(iabs(x))) * 180.0 / PI;
    endfunction

    function automatic logic signed [1:0] ref_angle(input int x, input int y);
        real d;
        if (x == 0 && y == 0) return 2'sd0;
        d = ref_deg(x, y);
        if (d < 22.5) return 2'sd0;
        if (d > 67.5) return -2'sd2;
        return ((x < 0) == (y < 0)) ? 2'sd1 : -2'sd1;
    endfunction

    function automatic bit near_boundary(input int x, input int y);
        real d;
        real e1;
        real e2;
        if (x == 0 && y == 0) return 1'b0;
        d  = ref_deg(x, y);
        e1 = (d > 22.5) ? d - 22.5 : 22.5 - d;
        e2 = (d > 67.5) ? d - 67.5 : 67.5 - d;
        return (e1 < 0.01) || (e2 < 0.01);
    endfunction

    task automatic fail(input string name, input int act, input int req);
        errors++;
        $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic applyStimulus(input int x, input int y,
                                 input logic signed [1:0] ea, input bit tol);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        gx       = 11'(x);
        gy       = 11'(y);
        e.due    = cyc + 2;
        e.ang    = ea;
        e.tol    = tol;
        e.mag    = 12'(iabs(x) + iabs(y));
        sb.push_back(e);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        in_valid = 1'b0;
        gx       = '0;
        gy       = '0;
    endtask

    task automatic checkOutput();
        exp_t e;
        bit   due;
        due = (sb.size() > 0) && (sb[0].due == cyc);
        checks++;
        if (out_valid !== due) fail("out_valid", int'(out_valid), int'(due));
        if (due) begin
            e = sb.pop_front();
            if (out_valid === 1'b1 && !e.tol) begin
                checks++;
                if (angle !== e.ang) fail("angle", int'(angle), int'(e.ang));
            end
`ifdef ARC_TAN_MAG_EN
            if (out_valid === 1'b1) begin
                checks++;
                if (mag !== e.mag) fail("mag", int'(mag), int'(e.mag));
            end
`endif
        end
    endtask

    always @(negedge clk) checkOutput();

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        gx       = '0;
        gy       = '0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) fail("reset out_valid", int'(out_valid), 0);
        checks++;
        if (angle !== 2'sd0) fail("reset angle", int'(angle), 0);
`ifdef ARC_TAN_MAG_EN
        checks++;
        if (mag !== 12'd0) fail("reset mag", int'(mag), 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released at cycle %0d", cyc);

        // Axes, diagonals and thresholds, issued back-to-back.
        applyStimulus(100, 0, 2'sd0, 1'b0);
        applyStimulus(0, -50, -2'sd2, 1'b0);
        applyStimulus(0, 0, 2'sd0, 1'b0);
        applyStimulus(100, 100, 2'sd1, 1'b0);
        applyStimulus(-100, 100, -2'sd1, 1'b0);
        applyStimulus(-75, -80, 2'sd1, 1'b0);
        applyStimulus(-1024, -1024, 2'sd1, 1'b0);
        applyStimulus(256, 106, 2'sd1, 1'b0);
        applyStimulus(256, 105, 2'sd0, 1'b0);
        applyStimulus(106, 256, -2'sd2, 1'b0);
        applyStimulus(1023, -1024, -2'sd1, 1'b0);
        applyStimulus(-1024, 0, 2'sd0, 1'b0);
        applyStimulus(0, -1024, -2'sd2, 1'b0);
        idleCycle();

        // Gap in the stream: the monitor expects out_valid=0 in the idle slot.
        applyStimulus(50, 20, 2'sd0, 1'b0);
        idleCycle();
        applyStimulus(20, -50, -2'sd2, 1'b0);
        idleCycle();
        idleCycle();

        // Mid-stream asynchronous reset discards in-flight results.
        applyStimulus(100, 100, 2'sd1, 1'b0);
        applyStimulus(-100, 100, -2'sd1, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b1) fail("pre-reset out_valid", int'(out_valid), 1);
        checks++;
        if (angle !== 2'sd1) fail("pre-reset angle", int'(angle), 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0) fail("async reset out_valid", int'(out_valid), 0);
        checks++;
        if (angle !== 2'sd0) fail("async reset angle", int'(angle), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idleCycle();
        applyStimulus(-30, 30, -2'sd1, 1'b0);
        idleCycle();

        // Coarse sweep against the atan2 reference.
        for (int x = -1024; x < 1024; x += 64) begin
            for (int y = -1024; y < 1024; y += 64) begin
                applyStimulus(x, y, ref_angle(x, y), near_boundary(x, y));
            end
        end
        repeat (4) idleCycle();

        checks++;
        if (sb.size() != 0) fail("scoreboard drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
